rx_timer: RTL and testbench
===========================

# rx_timer

Bit-timing generator for the UART receive path. While the receiver control unit holds `enable_timer` high, this block counts system clocks, issues a one-cycle `shift_strobe` at the centre of each data bit and of the stop bit, and pulses `packet_done` once the whole frame has been sampled. Its outputs drive the receive shift register and the control unit's `packet_done` input.

## Interface
- `CLKS_PER_BIT`, default 10: system clocks per serial bit. Legal range 4..255.
- `DATA_BITS`, default 8: data bits per frame. The stop bit is sampled as one extra bit, so each frame gives DATA_BITS+1 strobes.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `n_rst`  input  1  reset. Synchronous and active-high: when `n_rst`=1 at a rising edge, all state clears. The name follows the codebase port convention; the polarity is active-high.
- `enable_timer`  input  1  high while the control unit is in its data-read state.
- `shift_strobe`  output  1  one-cycle pulse at each bit-centre sample point. Registered.
- `packet_done`  output  1  one-cycle pulse after the final (stop-bit) strobe. Registered.
- `bit_period`  input  8  present only with `RX_TIMER_PROG_RATE_EN`; see Configuration.

## Operation
- **State machine:** three states, IDLE, COUNT and DONE. Reset state is IDLE.
- **Counters:**
  - `clk_cnt` counts enabled cycles in the current interval. Width is `$clog2(2*CLKS_PER_BIT)`.
  - `bit_cnt` counts strobes issued. Width is `$clog2(DATA_BITS+2)`.
  - Both counters are 0 in IDLE and after reset.
- **Interval lengths** (P = effective bit period):
  - FIRST = P + floor(P/2) − 2 enabled cycles. This compensates for the control unit's start-detect and pause latency, so the first strobe lands mid data bit 0.
  - Every following interval is exactly P cycles.
- **IDLE:**
  - If `enable_timer`=1 at an edge, go to COUNT with `clk_cnt`=1.
  - Otherwise stay in IDLE.
- **COUNT, with `enable_timer`=1 at an edge:**
  - If `clk_cnt` equals the current interval length, set `shift_strobe` for the next cycle, set `clk_cnt`=1 and increment `bit_cnt`.
  - Otherwise increment `clk_cnt`.
- **COUNT, end of frame:** the edge that issues strobe number DATA_BITS+1 also moves the FSM to DONE.
- **COUNT, abort:** if `enable_timer`=0 at an edge, go to IDLE and clear both counters. No strobe and no `packet_done` is produced.
- **DONE:**
  - `packet_done`=1 for exactly this one cycle.
  - `enable_timer` is ignored.
  - The next edge goes to IDLE.
- **Restart:** a new frame needs `enable_timer` sampled high in IDLE. If `enable_timer` is still high on leaving DONE, counting restarts immediately from `clk_cnt`=1.
- **Reset:** reset mid-frame takes priority over everything, returns to IDLE and drives both outputs to 0 on the following cycle. No partial pulse may appear.
- **Output overlap:** `shift_strobe` and `packet_done` are never high in the same cycle.

## Timing
- **Reset values:** `shift_strobe`=0 and `packet_done`=0.
- **Cycle numbering:** enabled edge 1 is the first edge at which `enable_timer`=1 is sampled in IDLE.
- **Strobe k** (k = 0..DATA_BITS) is high in the cycle after enabled edge FIRST + k·P.
  - With defaults (P=10, 8 data bits), strobes follow edges 13, 23, 33, …, 93.
- **`packet_done`** is high in the cycle after the final strobe cycle.
  - With defaults, it is high in the cycle following edge 94.
  - The stop bit has therefore been registered by the shift register before the control unit leaves its read state.
- **Total latency:** from the first enabled edge to `packet_done` is FIRST + DATA_BITS·P + 1 cycles.

## Configuration
- **`RX_TIMER_PROG_RATE_EN` defined:**
  - Adds the `bit_period[7:0]` input.
  - `bit_period` is latched on the IDLE→COUNT edge and used as P for the whole frame.
  - Changes to `bit_period` during a frame have no effect.
  - Values below 4 are treated as 4.
- **`RX_TIMER_PROG_RATE_EN` not defined:**
  - There is no `bit_period` port.
  - P = `CLKS_PER_BIT` as a constant.

## Test plan
- **Reset:** hold `n_rst`=1 for 3 cycles with `enable_timer`=1 → both outputs are 0 throughout and no strobe follows reset release until edge 13 of the new enable.
- **Nominal frame:** defaults, `enable_timer` high for 95 cycles → 9 single-cycle strobes after edges 13, 23, …, 93, and one `packet_done` after edge 94. Outputs never overlap.
- **Abort:** drop `enable_timer` after edge 40 (3 strobes issued) → no further strobe and no `packet_done`. Re-enabling gives its first strobe 13 enabled edges later.
- **Back-to-back frames:** keep `enable_timer` high through DONE → the second frame's first strobe comes 13 edges after the IDLE re-entry edge, and there are 9 strobes per frame.
- **Mid-frame reset:** pulse `n_rst` high for 1 cycle at edge 50 → outputs are 0 on the next cycle and counting restarts from the IDLE rules.
- **Programmable rate (`RX_TIMER_PROG_RATE_EN`):**
  - `bit_period`=16 → strobes after edges 22, 38, …, 150.
  - `bit_period`=2 → behaves exactly as 4 (first strobe after edge 4, then every 4).

Source files
------------

// File: rtl/rx_timer.sv
`timescale 1ns/1ps
// rx_timer: UART receive bit-timing generator (strobe at each data/stop bit centre, then packet_done).
// Latency: first strobe FIRST=P+P/2-2 enabled edges after enable, then every P; packet_done one cycle after last strobe.
// Flow: enable_timer low aborts the frame silently; optional RX_TIMER_PROG_RATE_EN adds a per-frame bit_period input.
module rx_timer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       enable_timer,
`ifdef RX_TIMER_PROG_RATE_EN
   input  logic [7:0] bit_period,
`endif
   output logic       shift_strobe,
   output logic       packet_done
);

`ifdef RX_TIMER_PROG_RATE_EN
   // Any 8-bit period is reachable, so size for the worst-case first interval.
   localparam int CW = 9;
`else
   localparam int CW = $clog2(2 * CLKS_PER_BIT);
`endif
   localparam int BW = $clog2(DATA_BITS + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   // Enabled cycles already counted in the current interval; the strobe edge
   // closes an interval, so the count returns to 0 there.
   logic [CW-1:0] clk_cnt;
   logic [BW-1:0] bit_cnt;
   logic [9:0]    period;
   logic [9:0]    first_m1;
   logic [9:0]    len_m1;

`ifdef RX_TIMER_PROG_RATE_EN
   logic [7:0] period_q;

   // Period is frozen for the whole frame, captured when counting starts.
   assign period = {2'b00, period_q};
`else
   assign period = 10'(CLKS_PER_BIT);
`endif

   // Terminal count for this interval: the first one is stretched to land mid data bit 0.
   always_comb begin
      first_m1 = period + (period >> 1) - 10'd3;
      len_m1   = (bit_cnt == '0) ? first_m1 : (period - 10'd1);
   end

   // Frame sequencer with registered strobe/done outputs.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state        <= IDLE;
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         shift_strobe <= 1'b0;
         packet_done  <= 1'b0;
`ifdef RX_TIMER_PROG_RATE_EN
         period_q     <= 8'd4;
`endif
      end else begin
         shift_strobe <= 1'b0;
         packet_done  <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (enable_timer) begin
                  state   <= COUNT;
                  clk_cnt <= CW'(1);
`ifdef RX_TIMER_PROG_RATE_EN
                  period_q <= (bit_period < 8'd4) ? 8'd4 : bit_period;
`endif
               end
            end
            COUNT: begin
               if (!enable_timer) begin
                  state   <= IDLE;
                  clk_cnt <= '0;
                  bit_cnt <= '0;
               end else if (10'(clk_cnt) == len_m1) begin
                  shift_strobe <= 1'b1;
                  clk_cnt      <= '0;
                  bit_cnt      <= bit_cnt + BW'(1);
                  if (bit_cnt == BW'(DATA_BITS)) begin
                     state <= DONE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DONE: begin
               // Stop-bit strobe is showing this cycle; done follows it, never alongside.
               packet_done <= 1'b1;
               state       <= IDLE;
               clk_cnt     <= '0;
               bit_cnt     <= '0;
            end
            default: begin
               state   <= IDLE;
               clk_cnt <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_timer.sv
`timescale 1ns/1ps
// tb_rx_timer: directed checks of strobe/done edge positions for rx_timer.
// Each edge is numbered; expected strobe/done edges are hand-derived per scenario.
// Outputs are sampled 1ns after each rising edge; inputs change at that point too.
module tb_rx_timer;

   logic clk;
   logic n_rst;
   logic enable_timer;
   logic shift_strobe;
   logic packet_done;
`ifdef RX_TIMER_PROG_RATE_EN
   logic [7:0] bit_period;
`endif

   int total;
   int bad;

   rx_timer #(
      .CLKS_PER_BIT(10),
      .DATA_BITS   (8)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .enable_timer(enable_timer),
`ifdef RX_TIMER_PROG_RATE_EN
      .bit_period  (bit_period),
`endif
      .shift_strobe(shift_strobe),
      .packet_done (packet_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive inputs for one edge, then sample just after it.
   task automatic cycle(input logic en, input logic rst);
      enable_timer = en;
      n_rst        = rst;
      @(posedge clk);
      #1;
   endtask

   // Enabled run of n edges; edge 1 is the first enabled edge sampled in IDLE.
   // Strobe expected after edges first, first+per, ... up to last; done after done_edge.
   task automatic run_en(input string tag, input int n, input int first, input int per,
                         input int last, input int done_edge);
      for (int e = 1; e <= n; e++) begin
         logic s_exp;
         logic d_exp;
         cycle(1'b1, 1'b0);
         s_exp = (e >= first) && (e <= last) && (((e - first) % per) == 0);
         d_exp = (e == done_edge);
         chk($sformatf("%s@%0d", tag, e), {30'd0, shift_strobe, packet_done}, {30'd0, s_exp, d_exp});
      end
   endtask

   task automatic run_idle(input string tag, input int n);
      for (int e = 1; e <= n; e++) begin
         cycle(1'b0, 1'b0);
         chk($sformatf("%s@%0d", tag, e), {30'd0, shift_strobe, packet_done}, 32'd0);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      enable_timer = 1'b0;
      n_rst        = 1'b1;
`ifdef RX_TIMER_PROG_RATE_EN
      bit_period   = 8'd10;
`endif

      // Reset held with enable high: outputs stay low.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1);
         chk($sformatf("rst%0d", i), {30'd0, shift_strobe, packet_done}, 32'd0);
      end
      // First strobe after release appears after enabled edge 13.
      run_en("post_rst", 14, 13, 10, 13, 0);
      run_idle("drain0", 3);

      // Nominal frame: strobes after 13..93, done after 94.
      run_en("nom", 94, 13, 10, 93, 94);
      cycle(1'b1, 1'b0);
      chk("nom@95", {30'd0, shift_strobe, packet_done}, 32'd0);
      run_idle("drain1", 3);

      // Abort after edge 40: three strobes, then silence.
      run_en("abort", 40, 13, 10, 93, 0);
      run_idle("abort_idle", 30);
      run_en("reenable", 14, 13, 10, 93, 0);
      run_idle("drain2", 3);

      // Back-to-back: second frame starts at edge 95 (one edge after IDLE re-entry at 94).
      run_en("b2b_f1", 94, 13, 10, 93, 94);
      run_en("b2b_f2", 94, 13, 10, 93, 94);
      run_idle("drain3", 3);

      // Mid-frame reset at edge 50.
      run_en("mid", 49, 13, 10, 93, 0);
      cycle(1'b1, 1'b1);
      chk("mid_rst@50", {30'd0, shift_strobe, packet_done}, 32'd0);
      run_en("mid_restart", 20, 13, 10, 93, 0);
      run_idle("drain4", 3);

`ifdef RX_TIMER_PROG_RATE_EN
      // Period 16: first interval 22, then 16; changing input mid-frame has no effect.
      bit_period = 8'd16;
      run_en("p16a", 30, 22, 16, 150, 151);
      bit_period = 8'd5;
      for (int e = 31; e <= 151; e++) begin
         logic s_exp;
         cycle(1'b1, 1'b0);
         s_exp = (e >= 22) && (e <= 150) && (((e - 22) % 16) == 0);
         chk($sformatf("p16b@%0d", e), {30'd0, shift_strobe, packet_done},
             {30'd0, s_exp, (e == 151)});
      end
      run_idle("drain5", 3);
      // Period 2 clamps to 4: strobes after 4,8,..,36; done after 37.
      bit_period = 8'd2;
      run_en("p2", 37, 4, 4, 36, 37);
      run_idle("drain6", 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
